// File: rtl/corr_peak_detect.sv
// -----------------------------------------------------------------------------
// corr_peak_detect
//
// Peak detector for a Schmidl-Cox timing metric. A metric at or above THRESH
// opens a search window of WIN_LEN accepted samples. The window includes the
// trigger sample. The largest metric in the window is kept, and the earliest
// sample wins a tie. When the window closes, o_sync pulses for one cycle.
// At the same edge, o_peak_val and o_peak_offset are loaded. The offset counts
// the accepted samples that followed the peak. HOLDOFF accepted samples are
// then ignored before the next trigger can occur.
//
// Ports
//   clk           : single rising-edge clock
//   reset_n       : synchronous active-low reset
//   i_enable      : global enable; when low, all state is frozen and o_sync is 0
//   i_corr        : unsigned 8-bit timing metric
//   i_corr_valid  : qualifies i_corr
//   o_sync        : one-cycle pulse at the end of a search window
//   o_peak_val    : maximum metric of the last completed window
//   o_peak_offset : accepted samples after the peak up to the window end
//   o_busy        : high while searching or in hold-off
//   o_sync_cnt    : number of syncs issued, modulo 256
// -----------------------------------------------------------------------------
module corr_peak_detect #(
    parameter logic [7:0] THRESH    = 8'd64,
    parameter int         WIN_LEN   = 128,
    parameter int         HOLDOFF   = 256,
    parameter int         CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic [7:0]           i_corr,
    input  logic                 i_corr_valid,
    output logic                 o_sync,
    output logic [7:0]           o_peak_val,
    output logic [CTR_WIDTH-1:0] o_peak_offset,
    output logic                 o_busy,
    output logic [7:0]           o_sync_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [CTR_WIDTH-1:0] ZERO_C    = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] ONE_C     = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CTR_WIDTH-1:0] WIN_LEN_C = CTR_WIDTH'(WIN_LEN);
    localparam logic [CTR_WIDTH-1:0] HOLD_C    = CTR_WIDTH'(HOLDOFF);

    logic [1:0]           state_q,  state_d;
    logic [7:0]           peak_q,   peak_d;
    logic [CTR_WIDTH-1:0] since_q,  since_d;
    logic [CTR_WIDTH-1:0] win_q,    win_d;
    logic [CTR_WIDTH-1:0] hold_q,   hold_d;
    logic                 sync_q,   sync_d;
    logic [7:0]           pval_q,   pval_d;
    logic [CTR_WIDTH-1:0] poff_q,   poff_d;
    logic                 busy_q,   busy_d;
    logic [7:0]           cnt_q,    cnt_d;

    logic accept_s;
    logic in_window_s;

    assign accept_s = i_enable & i_corr_valid;

    // Next-state logic: window tracking, peak compare and sync generation.
    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        since_d     = since_q;
        win_d       = win_q;
        hold_d      = hold_q;
        sync_d      = 1'b0;
        pval_d      = pval_q;
        poff_d      = poff_q;
        cnt_d       = cnt_q;
        in_window_s = 1'b0;

        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_corr >= THRESH) begin
                        in_window_s = 1'b1;
                        peak_d      = i_corr;
                        since_d     = ZERO_C;
                        win_d       = ONE_C;
                    end else begin
                        in_window_s = 1'b0;
                    end
                end
                ST_SEARCH: begin
                    in_window_s = 1'b1;
                    win_d       = win_q + ONE_C;
                    // A strict compare keeps the earliest peak on a tie.
                    if (i_corr > peak_q) begin
                        peak_d  = i_corr;
                        since_d = ZERO_C;
                    end else begin
                        since_d = since_q + ONE_C;
                    end
                end
                ST_HOLDOFF: begin
                    hold_d = hold_q + ONE_C;
                    // The sample that ends hold-off is consumed here. It is never
                    // compared against THRESH, so it cannot trigger.
                    if (hold_d == HOLD_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // The window can close on its trigger sample when WIN_LEN is 1.
            // Both the IDLE and SEARCH paths therefore share this check.
            if (in_window_s) begin
                if (win_d == WIN_LEN_C) begin
                    sync_d  = 1'b1;
                    pval_d  = peak_d;
                    poff_d  = since_d;
                    cnt_d   = cnt_q + 8'd1;
                    hold_d  = ZERO_C;
                    state_d = (HOLD_C == ZERO_C) ? ST_IDLE : ST_HOLDOFF;
                end else begin
                    state_d = ST_SEARCH;
                end
            end else begin
                in_window_s = 1'b0;
            end
        end else begin
            sync_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            peak_q  <= 8'd0;
            since_q <= ZERO_C;
            win_q   <= ZERO_C;
            hold_q  <= ZERO_C;
            sync_q  <= 1'b0;
            pval_q  <= 8'd0;
            poff_q  <= ZERO_C;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            since_q <= since_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            sync_q  <= sync_d;
            pval_q  <= pval_d;
            poff_q  <= poff_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_sync        = sync_q;
    assign o_peak_val    = pval_q;
    assign o_peak_offset = poff_q;
    assign o_busy        = busy_q;
    assign o_sync_cnt    = cnt_q;

endmodule

// File: tb/tb_corr_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_corr_peak_detect
//
// Two instances share one input stream:
//   a : THRESH=64, WIN_LEN=8, HOLDOFF=4
//   b : THRESH=64, WIN_LEN=1, HOLDOFF=0
// A sample-level reference model keeps the window contents as a buffer.
// It finds the peak when the window closes.
// -----------------------------------------------------------------------------
module tb_corr_peak_detect;

    localparam int WL_A = 8;
    localparam int HL_A = 4;
    localparam int WL_B = 1;
    localparam int HL_B = 0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_enable;
    logic [7:0]  i_corr;
    logic        i_corr_valid;

    logic        a_sync, b_sync;
    logic [7:0]  a_val, b_val;
    logic [15:0] a_off, b_off;
    logic        a_busy, b_busy;
    logic [7:0]  a_cnt, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    corr_peak_detect #(.THRESH(8'd64), .WIN_LEN(WL_A), .HOLDOFF(HL_A), .CTR_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_corr(i_corr),
        .i_corr_valid(i_corr_valid), .o_sync(a_sync), .o_peak_val(a_val),
        .o_peak_offset(a_off), .o_busy(a_busy), .o_sync_cnt(a_cnt));

    corr_peak_detect #(.THRESH(8'd64), .WIN_LEN(WL_B), .HOLDOFF(HL_B), .CTR_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_corr(i_corr),
        .i_corr_valid(i_corr_valid), .o_sync(b_sync), .o_peak_val(b_val),
        .o_peak_offset(b_off), .o_busy(b_busy), .o_sync_cnt(b_cnt));

    // Reference model state, indexed by instance (0 = a, 1 = b).
    int         m_wlen [2];
    int         m_hlen [2];
    bit         m_inwin[2];
    int         m_wcnt [2];
    int         m_hrem [2];
    logic [7:0] m_buf  [2][0:15];
    bit         e_sync [2];
    int         e_val  [2];
    int         e_off  [2];
    int         e_cnt  [2];
    bit         e_busy [2];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic close_window(input int m);
        int k;
        k = 0;
        for (int i = 1; i < m_wcnt[m]; i++) begin
            if (m_buf[m][i] > m_buf[m][k]) k = i;
        end
        e_val[m]   = int'(m_buf[m][k]);
        e_off[m]   = m_wcnt[m] - 1 - k;
        e_sync[m]  = 1'b1;
        e_cnt[m]   = (e_cnt[m] + 1) % 256;
        m_inwin[m] = 1'b0;
        m_hrem[m]  = m_hlen[m];
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic v, input logic [7:0] c);
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                m_inwin[m] = 1'b0;
                m_wcnt[m]  = 0;
                m_hrem[m]  = 0;
                e_sync[m]  = 1'b0;
                e_val[m]   = 0;
                e_off[m]   = 0;
                e_cnt[m]   = 0;
            end else begin
                e_sync[m] = 1'b0;
                if (en && v) begin
                    if (m_hrem[m] > 0) begin
                        m_hrem[m]--;
                    end else begin
                        if (!m_inwin[m] && c >= 8'd64) begin
                            m_inwin[m] = 1'b1;
                            m_wcnt[m]  = 0;
                        end
                        if (m_inwin[m]) begin
                            m_buf[m][m_wcnt[m]] = c;
                            m_wcnt[m]++;
                            if (m_wcnt[m] == m_wlen[m]) close_window(m);
                        end
                    end
                end
            end
            e_busy[m] = m_inwin[m] || (m_hrem[m] > 0);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic v, input logic [7:0] c);
        reset_n      = rst;
        i_enable     = en;
        i_corr_valid = v;
        i_corr       = c;
        @(posedge clk);
        model_edge(rst, en, v, c);
        #1;
        check_val("a_sync", int'(a_sync), int'(e_sync[0]));
        check_val("a_val",  int'(a_val),  e_val[0]);
        check_val("a_off",  int'(a_off),  e_off[0]);
        check_val("a_busy", int'(a_busy), int'(e_busy[0]));
        check_val("a_cnt",  int'(a_cnt),  e_cnt[0]);
        check_val("b_sync", int'(b_sync), int'(e_sync[1]));
        check_val("b_val",  int'(b_val),  e_val[1]);
        check_val("b_off",  int'(b_off),  e_off[1]);
        check_val("b_busy", int'(b_busy), int'(e_busy[1]));
        check_val("b_cnt",  int'(b_cnt),  e_cnt[1]);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 64 && e_busy[0]; i++) step(1'b1, 1'b1, 1'b1, 8'd10);
        check_val("drain_idle", int'(a_busy), 0);
    endtask

    logic [7:0] s033 [0:8];

    initial begin
        m_wlen[0] = WL_A; m_hlen[0] = HL_A;
        m_wlen[1] = WL_B; m_hlen[1] = HL_B;
        s033 = '{8'd10, 8'd70, 8'd80, 8'd120, 8'd90, 8'd120, 8'd50, 8'd40, 8'd30};

        // Reset state
        step(1'b0, 1'b1, 1'b1, 8'd200);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("rst_val", int'(a_val), 0);
        check_val("rst_busy", int'(a_busy), 0);

        // Reference stream: the window closes on the sample 30
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, s033[i]);
        check_val("s033_sync", int'(a_sync), 1);
        check_val("s033_val",  int'(a_val), 120);
        check_val("s033_off",  int'(a_off), 5);
        check_val("s033_cnt",  int'(a_cnt), 1);
        check_val("s033_busy", int'(a_busy), 1);

        // Hold-off ignores strong samples; the next one triggers
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 8'd200);
        check_val("hold_end_busy", int'(a_busy), 0);
        step(1'b1, 1'b1, 1'b1, 8'd200);
        check_val("retrig_busy", int'(a_busy), 1);
        drain_a();

        // Only valid cycles count
        step(1'b1, 1'b1, 1'b1, 8'd70);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, (i % 2 == 0), (i % 2 == 0) ? 8'd0 : 8'd250);
        check_val("valid_sync", int'(a_sync), 1);
        check_val("valid_val",  int'(a_val), 70);
        check_val("valid_off",  int'(a_off), 7);
        drain_a();

        // Reset during a window
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 8'd100);
        step(1'b0, 1'b1, 1'b1, 8'd100);
        check_val("midrst_sync", int'(a_sync), 0);
        check_val("midrst_cnt",  int'(a_cnt), 0);
        check_val("midrst_off",  int'(a_off), 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 8'd100);
        check_val("post_rst_val", int'(a_val), 100);
        check_val("post_rst_off", int'(a_off), 7);
        drain_a();

        // Enable low freezes a window in progress
        step(1'b1, 1'b1, 1'b1, 8'd70);
        step(1'b1, 1'b1, 1'b1, 8'd80);
        step(1'b1, 1'b1, 1'b1, 8'd60);
        step(1'b1, 1'b1, 1'b1, 8'd90);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'd255);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 8'd10);
        check_val("freeze_sync", int'(a_sync), 1);
        check_val("freeze_val",  int'(a_val), 90);
        check_val("freeze_off",  int'(a_off), 4);
        drain_a();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom_range(0, 255)));
        end

        // Sync counter wrap: 256 windows of 12 samples each
        step(1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 256 * 12; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'd200);
            if (i == 255 * 12 - 5) check_val("cnt_255", int'(a_cnt), 255);
        end
        check_val("cnt_wrap", int'(a_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
